rgb_pwm_driver: RTL and testbench

- Downstream consumer of the tick pulse from binaryPulser. Turns each 1-cycle tick into one PWM step for three colour channels (R, G, B).
- Duty values arrive through a valid/ready handshake. They are held in a pending register and committed only at a period boundary, so the LEDs never glitch mid-period.
- Sits between the pulser and the board RGB LED pins.

---
 rtl/rgb_pkg.sv | 17 +
 rtl/pwm_channel.sv | 76 +++++++
 rtl/rgb_pwm_driver.sv | 136 +++++++++++++
 tb/tb_rgb_pwm_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and defaults for the RGB PWM driver and its colour channels.
package rgb_pkg;

    localparam int RES_DEFAULT = 8;

    typedef struct packed {
        logic [RES_DEFAULT-1:0] r;
        logic [RES_DEFAULT-1:0] g;
        logic [RES_DEFAULT-1:0] b;
    } rgb_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: active duty register, registered compare and duty stepper.
// With RGB_FADE_EN defined the active duty walks toward its target by FADE_STEP per commit.
module pwm_channel #(
    parameter int RES       = 8,
    parameter int FADE_STEP = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [RES-1:0] phase,
    input  logic           commit,
    input  logic [RES-1:0] target,
    output logic           settled,
    output logic           pwm
);

    logic [RES-1:0] active_d;
    logic [RES-1:0] active_q;
    logic [RES-1:0] next_s;
    logic           pwm_d;
    logic           pwm_q;

`ifdef RGB_FADE_EN
    localparam logic [RES-1:0] STEP = RES'(FADE_STEP);

    // Step toward the target, landing exactly on it instead of overshooting.
    always_comb begin
        next_s = active_q;
        if (target > active_q) begin
            if ((target - active_q) > STEP) begin
                next_s = active_q + STEP;
            end else begin
                next_s = target;
            end
        end else if (target < active_q) begin
            if ((active_q - target) > STEP) begin
                next_s = active_q - STEP;
            end else begin
                next_s = target;
            end
        end else begin
            next_s = target;
        end
    end
`else
    logic unused_fade_s;
    assign unused_fade_s = (FADE_STEP != 32'sd0);
    assign next_s        = target;
`endif

    assign settled = (next_s == target);
    assign pwm     = pwm_q;

    // Active duty update at commit and PWM compare against the current phase.
    always_comb begin
        active_d = active_q;
        if (commit) begin
            active_d = next_s;
        end else begin
            active_d = active_q;
        end
        pwm_d = run && (phase < active_q);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= {RES{1'b0}};
            pwm_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver stepped by an external tick; new colours commit only at period wrap.
// Optional RGB_FADE_EN makes each commit a gradual fade of FADE_STEP per period.
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int RES       = RES_DEFAULT,
    parameter int FADE_STEP = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           enable,
    input  logic           duty_valid,
    output logic           duty_ready,
    input  logic [RES-1:0] duty_r,
    input  logic [RES-1:0] duty_g,
    input  logic [RES-1:0] duty_b,
    output logic           pwm_r,
    output logic           pwm_g,
    output logic           pwm_b,
    output logic           period_start
);

    localparam logic [RES-1:0] MAXP      = {{(RES-1){1'b1}}, 1'b0};
    localparam logic [RES-1:0] PHASE_ONE = {{(RES-1){1'b0}}, 1'b1};

    pwm_state_t     state_d, state_q;
    logic [RES-1:0] phase_d, phase_q;
    logic [RES-1:0] pend_r_d, pend_r_q;
    logic [RES-1:0] pend_g_d, pend_g_q;
    logic [RES-1:0] pend_b_d, pend_b_q;
    logic           pend_full_d, pend_full_q;
    logic           period_start_d, period_start_q;
    logic           step_s;
    logic           boundary_s;
    logic           commit_s;
    logic           capture_s;
    logic           run_s;
    logic [2:0]     settled_s;

    // Run/stop FSM and phase counter; a falling enable wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d = {RES{1'b0}};
                if (enable) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    phase_d = {RES{1'b0}};
                end else if (tick) begin
                    step_s  = 1'b1;
                    phase_d = (phase_q == MAXP) ? {RES{1'b0}} : (phase_q + PHASE_ONE);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = {RES{1'b0}};
            end
        endcase
    end

    assign run_s          = (state_q == RUN);
    assign boundary_s     = step_s && (phase_q == MAXP);
    assign period_start_d = boundary_s;
    assign capture_s      = duty_valid && !pend_full_q;
    assign commit_s       = boundary_s && pend_full_q;

    // Pending colour register; a capture on a boundary edge waits for the next boundary.
    always_comb begin
        pend_r_d    = pend_r_q;
        pend_g_d    = pend_g_q;
        pend_b_d    = pend_b_q;
        pend_full_d = pend_full_q;
        if (capture_s) begin
            pend_r_d    = duty_r;
            pend_g_d    = duty_g;
            pend_b_d    = duty_b;
            pend_full_d = 1'b1;
        end else if (commit_s && (&settled_s)) begin
            pend_full_d = 1'b0;
        end else begin
            pend_full_d = pend_full_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            phase_q        <= {RES{1'b0}};
            pend_r_q       <= {RES{1'b0}};
            pend_g_q       <= {RES{1'b0}};
            pend_b_q       <= {RES{1'b0}};
            pend_full_q    <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            pend_r_q       <= pend_r_d;
            pend_g_q       <= pend_g_d;
            pend_b_q       <= pend_b_d;
            pend_full_q    <= pend_full_d;
            period_start_q <= period_start_d;
        end
    end

    assign duty_ready   = !pend_full_q;
    assign period_start = period_start_q;

    pwm_channel #(.RES(RES), .FADE_STEP(FADE_STEP)) u_ch_r (
        .clk(clk), .reset(reset), .run(run_s), .phase(phase_q), .commit(commit_s),
        .target(pend_r_q), .settled(settled_s[0]), .pwm(pwm_r)
    );

    pwm_channel #(.RES(RES), .FADE_STEP(FADE_STEP)) u_ch_g (
        .clk(clk), .reset(reset), .run(run_s), .phase(phase_q), .commit(commit_s),
        .target(pend_g_q), .settled(settled_s[1]), .pwm(pwm_g)
    );

    pwm_channel #(.RES(RES), .FADE_STEP(FADE_STEP)) u_ch_b (
        .clk(clk), .reset(reset), .run(run_s), .phase(phase_q), .commit(commit_s),
        .target(pend_b_q), .settled(settled_s[2]), .pwm(pwm_b)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver at RES=4 with a tick every third clock; expected per-period
// high counts are queued by the stimulus and checked by a monitor at each period_start.
module tb_rgb_pwm_driver;

    localparam int RES = 4;

    logic           clk;
    logic           reset;
    logic           tick;
    logic           enable;
    logic           duty_valid;
    logic           duty_ready;
    logic [RES-1:0] duty_r, duty_g, duty_b;
    logic           pwm_r, pwm_g, pwm_b;
    logic           period_start;

    typedef struct {
        bit chk;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   tcnt;

    rgb_pwm_driver #(.RES(RES), .FADE_STEP(2)) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable),
        .duty_valid(duty_valid), .duty_ready(duty_ready),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
        .period_start(period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running tick: one clock high out of every three.
    initial begin
        tick = 1'b0;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt == 2) ? 0 : tcnt + 1;
            tick = (tcnt == 2);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit c, input int r, input int g, input int b);
        exp_t e;
        e.chk = c;
        e.r   = r;
        e.g   = g;
        e.b   = b;
        exp_q.push_back(e);
    endtask

    // Monitor: count high samples per period; each tick lasts 3 clocks, so count = duty*3.
    initial begin
        int   cr, cg, cb;
        bit   ps_prev;
        exp_t e;
        cr = 0; cg = 0; cb = 0; ps_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cr = 0; cg = 0; cb = 0;
            end else begin
                cr += int'(pwm_r);
                cg += int'(pwm_g);
                cb += int'(pwm_b);
                if (period_start) begin
                    chk("ps_width", int'(ps_prev), 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_period", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.chk) begin
                            chk("period_r", cr, e.r * 3);
                            chk("period_g", cg, e.g * 3);
                            chk("period_b", cb, e.b * 3);
                        end
                    end
                    cr = 0; cg = 0; cb = 0;
                end
            end
            ps_prev = period_start;
        end
    end

    task automatic wait_ps(input int exp_prev_rdy, input int exp_rdy);
        int prev;
        bit seen;
        prev = int'(duty_ready);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (period_start) begin
                seen = 1'b1;
                break;
            end
            prev = int'(duty_ready);
        end
        chk("ps_timeout", int'(seen), 1);
        if (seen) begin
            chk("rdy_before_ps", prev, exp_prev_rdy);
            chk("rdy_at_ps", int'(duty_ready), exp_rdy);
        end
    endtask

    task automatic load(input int r, input int g, input int b);
        duty_valid = 1'b1;
        duty_r     = 4'(r);
        duty_g     = 4'(g);
        duty_b     = 4'(b);
        chk("load_ready", int'(duty_ready), 1);
        @(negedge clk);
        duty_valid = 1'b0;
        chk("ready_drop", int'(duty_ready), 0);
    endtask

    initial begin
        int n;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        enable     = 1'b0;
        duty_valid = 1'b0;
        duty_r     = 4'd0;
        duty_g     = 4'd0;
        duty_b     = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        chk("rst_ready", int'(duty_ready), 1);
        chk("rst_ps", int'(period_start), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);

`ifdef RGB_FADE_EN
        load(5, 0, 4);
        enable = 1'b1;
        push(1'b1, 0, 0, 0); wait_ps(0, 0);
        push(1'b1, 2, 0, 2); wait_ps(0, 0);
        push(1'b1, 4, 0, 4); wait_ps(0, 1);
        push(1'b1, 5, 0, 4); wait_ps(1, 1);
`else
        // Colour loaded while idle only takes effect at the first boundary.
        load(5, 0, 15);
        repeat (10) @(negedge clk);
        chk("idle_hold_ready", int'(duty_ready), 0);
        enable = 1'b1;
        push(1'b1, 0, 0, 0);  wait_ps(0, 1);
        push(1'b1, 5, 0, 15); wait_ps(1, 1);

        // Mid-period load; a second offer while not ready must be ignored.
        push(1'b1, 5, 0, 15);
        repeat (10) @(negedge clk);
        load(3, 8, 1);
        duty_valid = 1'b1;
        duty_r = 4'd9; duty_g = 4'd9; duty_b = 4'd9;
        repeat (3) @(negedge clk);
        chk("ignored_ready", int'(duty_ready), 0);
        duty_valid = 1'b0;
        wait_ps(0, 1);

        // Capture on the exact boundary edge commits one period later.
        push(1'b1, 3, 8, 1);
        repeat (44) @(negedge clk);
        duty_valid = 1'b1;
        duty_r = 4'd7; duty_g = 4'd2; duty_b = 4'd12;
        chk("bnd_offer_ready", int'(duty_ready), 1);
        @(negedge clk);
        duty_valid = 1'b0;
        chk("bnd_ps", int'(period_start), 1);
        chk("bnd_ready", int'(duty_ready), 0);
        push(1'b1, 3, 8, 1);  wait_ps(0, 1);
        push(1'b1, 7, 2, 12); wait_ps(1, 1);

        // Drop enable at phase 7, then restart and time the first period.
        push(1'b0, 0, 0, 0);
        repeat (21) @(negedge clk);
        chk("pre_drop_b", int'(pwm_b), 1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("drop_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        repeat (20) @(negedge clk);
        chk("stopped_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        enable = 1'b1;
        n = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (tick) n++;
            #1;
            if (period_start) break;
        end
        chk("reenable_ticks", n, 15);
        @(negedge clk);
        push(1'b1, 7, 2, 12); wait_ps(1, 1);
`endif

        // Asynchronous reset mid-period discards the pending colour.
        load(1, 1, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_rst_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        chk("async_rst_ready", int'(duty_ready), 1);
        chk("async_rst_ps", int'(period_start), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        chk("post_rst_ready", int'(duty_ready), 1);
        enable = 1'b1;
        push(1'b1, 0, 0, 0); wait_ps(1, 1);
        push(1'b1, 0, 0, 0); wait_ps(1, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
